// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: time-multiplexed scan of NUM_DIGITS hex digits through
// one shared 7-segment decoder. Each digit slot opens with BLANK_CYCLES of
// all-digits-off so the decoder settles before the next digit lights.
// Displayed data is a frame-coherent snapshot taken at the frame boundary.
// Optional build macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits).
module seven_seg_scan_ctrl #(
   parameter int NUM_DIGITS          = 4,
   parameter int REFRESH_DIV         = 50000,
   parameter int BLANK_CYCLES        = 64,
   parameter int DIGIT_EN_ACTIVE_LOW = 1
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [4*NUM_DIGITS-1:0] i_value,
   input  logic [NUM_DIGITS-1:0]   i_dp,
   input  logic                    i_load,
   output logic [3:0]              o_nibble,
   output logic                    o_dp,
   output logic [NUM_DIGITS-1:0]   o_digit_en,
   output logic                    o_frame_done
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = $clog2(NUM_DIGITS);

   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] EN_OFF =
      (DIGIT_EN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

   typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_e;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] act_val_q, act_val_d;
   logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
   logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
   logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
   logic                    pend_vld_q, pend_vld_d;

   logic [3:0]              nibble_d;
   logic                    dp_d;
   logic [NUM_DIGITS-1:0]   digit_en_d;
   logic                    frame_done_d;

   logic cnt_last, idx_last, frame_bnd;

   assign cnt_last  = (cnt_q == CNT_LAST);
   assign idx_last  = (idx_q == IDX_LAST);
   assign frame_bnd = (cnt_q == '0) && (idx_q == '0);

   // Slot counter and digit index step together; index advances on slot wrap
   always_comb begin
      cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
      idx_d = idx_q;
      if (cnt_last) idx_d = idx_last ? '0 : idx_q + IDX_W'(1);
   end

   // State register: counter, index and BLANK/SHOW phase
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_BLANK;
         cnt_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
      end
   end

   // Next-state logic: BLANK for the first BLANK_CYCLES counts of each slot
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_BLANK: if (cnt_q == BLANK_LAST) state_d = ST_SHOW;
         ST_SHOW:  if (cnt_last)            state_d = ST_BLANK;
         default:                           state_d = ST_BLANK;
      endcase
   end

   // Snapshot capture: loads park in pending, promoted only at the frame
   // boundary; a load landing on the boundary itself goes straight to active
   always_comb begin
      act_val_d  = act_val_q;
      act_dp_d   = act_dp_q;
      pend_val_d = pend_val_q;
      pend_dp_d  = pend_dp_q;
      pend_vld_d = pend_vld_q;
      if (frame_bnd) begin
         if (i_load) begin
            act_val_d = i_value;
            act_dp_d  = i_dp;
         end else if (pend_vld_q) begin
            act_val_d = pend_val_q;
            act_dp_d  = pend_dp_q;
         end
         pend_vld_d = 1'b0;
      end else if (i_load) begin
         pend_val_d = i_value;
         pend_dp_d  = i_dp;
         pend_vld_d = 1'b1;
      end
   end

   // Active / pending value registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         act_val_q  <= '0;
         act_dp_q   <= '0;
         pend_val_q <= '0;
         pend_dp_q  <= '0;
         pend_vld_q <= 1'b0;
      end else begin
         act_val_q  <= act_val_d;
         act_dp_q   <= act_dp_d;
         pend_val_q <= pend_val_d;
         pend_dp_q  <= pend_dp_d;
         pend_vld_q <= pend_vld_d;
      end
   end

   // Output logic: uses the post-boundary snapshot so a boundary load is
   // visible from the very first slot of its frame
   always_comb begin
      logic                  show_ok;
      logic [NUM_DIGITS-1:0] onehot;
`ifdef LEADING_ZERO_BLANK_EN
      logic [NUM_DIGITS-1:0] hi_zero;
`endif
      nibble_d = 4'h0;
      dp_d     = 1'b0;
      onehot   = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            nibble_d  = act_val_d[4*k +: 4];
            dp_d      = act_dp_d[k];
            onehot[k] = 1'b1;
         end
      end
`ifdef LEADING_ZERO_BLANK_EN
      // hi_zero[k]: digit k and everything above it are zero with no dp
      hi_zero = '0;
      hi_zero[NUM_DIGITS-1] = (act_val_d[4*NUM_DIGITS-4 +: 4] == 4'h0) &&
                              !act_dp_d[NUM_DIGITS-1];
      for (int k = NUM_DIGITS - 2; k >= 0; k--)
         hi_zero[k] = hi_zero[k+1] && (act_val_d[4*k +: 4] == 4'h0) && !act_dp_d[k];
      show_ok = 1'b1;
      for (int k = 1; k < NUM_DIGITS; k++)
         if (idx_q == IDX_W'(k) && hi_zero[k]) show_ok = 1'b0;
`else
      show_ok = 1'b1;
`endif
      if (state_q == ST_SHOW && show_ok)
         digit_en_d = (DIGIT_EN_ACTIVE_LOW != 0) ? ~onehot : onehot;
      else
         digit_en_d = EN_OFF;
      frame_done_d = idx_last && cnt_last;
   end

   // Registered outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_nibble     <= 4'h0;
         o_dp         <= 1'b0;
         o_digit_en   <= EN_OFF;
         o_frame_done <= 1'b0;
      end else begin
         o_nibble     <= nibble_d;
         o_dp         <= dp_d;
         o_digit_en   <= digit_en_d;
         o_frame_done <= frame_done_d;
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: behavioural model driven by absolute cycle
// count since reset, directed literal checks, then randomized loads/resets.
module tb_seven_seg_scan_ctrl;
   localparam int N  = 4;
   localparam int R  = 8;
   localparam int B  = 2;
   localparam int AL = 1;
   localparam logic [N-1:0] OFF = {N{1'b1}};

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [4*N-1:0] value = '0;
   logic [N-1:0]   dpi = '0;
   logic           load = 1'b0;
   logic [3:0]     o_nibble;
   logic           o_dp;
   logic [N-1:0]   o_digit_en;
   logic           o_frame_done;

   int nvec = 0;
   int nerr = 0;

   seven_seg_scan_ctrl #(
      .NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B), .DIGIT_EN_ACTIVE_LOW(AL)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_value(value), .i_dp(dpi), .i_load(load),
      .o_nibble(o_nibble), .o_dp(o_dp), .o_digit_en(o_digit_en),
      .o_frame_done(o_frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: cycle number since reset release, snapshot and pending load
   int             m_cyc = 0;
   logic [4*N-1:0] m_act = '0, m_pend = '0;
   logic [N-1:0]   m_adp = '0, m_pdp = '0;
   logic           m_pv = 1'b0;
   logic [3:0]     exp_nib = '0;
   logic           exp_dp = 1'b0;
   logic [N-1:0]   exp_en = OFF;
   logic           exp_fd = 1'b0;

   // Outputs after the edge ending cycle c describe cycle c's slot position
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cyc <= 0; m_act <= '0; m_adp <= '0; m_pend <= '0; m_pdp <= '0; m_pv <= 1'b0;
         exp_nib <= '0; exp_dp <= 1'b0; exp_en <= OFF; exp_fd <= 1'b0;
      end else begin : mdl
         int c, cnt, idx;
         logic [4*N-1:0] a, p;
         logic [N-1:0] d, pd, oh;
         logic pv, on;
         c = m_cyc; a = m_act; d = m_adp; p = m_pend; pd = m_pdp; pv = m_pv;
         if (c % (N*R) == 0) begin
            if (load) begin a = value; d = dpi; end
            else if (pv) begin a = p; d = pd; end
            pv = 1'b0;
         end else if (load) begin
            p = value; pd = dpi; pv = 1'b1;
         end
         cnt = c % R;
         idx = (c / R) % N;
         on = (cnt >= B);
`ifdef LEADING_ZERO_BLANK_EN
         if (idx != 0 && ((a >> (4*idx)) == 0) && ((d >> idx) == 0)) on = 1'b0;
`endif
         oh = '0;
         oh[idx] = 1'b1;
         exp_nib <= 4'((a >> (4*idx)) & 'hF);
         exp_dp  <= d[idx];
         exp_en  <= on ? ((AL != 0) ? ~oh : oh) : OFF;
         exp_fd  <= (idx == N-1) && (cnt == R-1);
         m_cyc <= c + 1; m_act <= a; m_adp <= d; m_pend <= p; m_pdp <= pd; m_pv <= pv;
      end
   end

   // Compare every cycle, away from the active edge
   always @(negedge clk) begin
      chk("nibble", int'(o_nibble), int'(exp_nib));
      chk("dp", int'(o_dp), int'(exp_dp));
      chk("digit_en", int'(o_digit_en), int'(exp_en));
      chk("frame_done", int'(o_frame_done), int'(exp_fd));
   end

   task automatic wait_cyc(input int t);
      int guard = 0;
      while (m_cyc != t && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      if (m_cyc != t) chk("wait_cyc", m_cyc, t);
   endtask

   task automatic load_at(input int t, input logic [4*N-1:0] v, input logic [N-1:0] d);
      wait_cyc(t);
      value = v; dpi = d; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      // Reset release, no load
      wait_cyc(1);  chk("lit_en_blank", int'(o_digit_en), 'hF);
      wait_cyc(3);  chk("lit_en_d0", int'(o_digit_en), 'hE);
                    chk("lit_nib_d0", int'(o_nibble), 0);
      wait_cyc(11); chk("lit_en_d1", int'(o_digit_en), 'hD);
      // Load 1234 before the frame boundary
      load_at(20, 16'h1234, 4'b0100);
      wait_cyc(32); chk("lit_fd32", int'(o_frame_done), 1);
      wait_cyc(33); chk("lit_fd33", int'(o_frame_done), 0);
      wait_cyc(35); chk("lit_nib4", int'(o_nibble), 4);
                    chk("lit_dp_d0", int'(o_dp), 0);
      wait_cyc(51); chk("lit_nib2", int'(o_nibble), 2);
                    chk("lit_dp_d2", int'(o_dp), 1);
                    chk("lit_en_d2", int'(o_digit_en), 'hB);
      wait_cyc(64); chk("lit_fd64", int'(o_frame_done), 1);
      // Mid-frame load must not tear
      load_at(66, 16'hABCD, 4'b0000);
      wait_cyc(84);  chk("lit_notear", int'(o_nibble), 2);
      wait_cyc(100); chk("lit_newD", int'(o_nibble), 'hD);
      // Load exactly on the frame boundary
      load_at(128, 16'h0F00, 4'b0000);
      wait_cyc(132); chk("lit_bnd_d0", int'(o_nibble), 0);
      wait_cyc(148); chk("lit_bnd_d2", int'(o_nibble), 'hF);
      // Asynchronous reset during SHOW of digit 2
      wait_cyc(181); chk("lit_pre_rst", int'(o_digit_en), 'hB);
      #2 rst_n = 1'b0;
      #1 chk("lit_async_en", int'(o_digit_en), 'hF);
         chk("lit_async_nib", int'(o_nibble), 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      wait_cyc(3);  chk("lit_rst_en", int'(o_digit_en), 'hE);
      // Leading-zero case
      load_at(5, 16'h0050, 4'b0000);
      wait_cyc(19); chk("lit_rst_act0", int'(o_nibble), 0);
      wait_cyc(44); chk("lit_lz_d1", int'(o_nibble), 5);
                    chk("lit_lz_en1", int'(o_digit_en), 'hD);
`ifdef LEADING_ZERO_BLANK_EN
      wait_cyc(52); chk("lit_lz_en2", int'(o_digit_en), 'hF);
      wait_cyc(60); chk("lit_lz_en3", int'(o_digit_en), 'hF);
`else
      wait_cyc(52); chk("lit_lz_en2", int'(o_digit_en), 'hB);
      wait_cyc(60); chk("lit_lz_en3", int'(o_digit_en), 'h7);
`endif
      // Randomized loads (sparse values favour leading zeros) and resets
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         load = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 1) == 0) value = 16'($urandom);
         else value = 16'($urandom_range(0, 255));
         dpi = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
         if ($urandom_range(0, 700) == 0) begin
            #2 rst_n = 1'b0;
            @(negedge clk); @(negedge clk);
            rst_n = 1'b1;
         end
      end
      @(negedge clk);
      load = 1'b0;
      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Time-multiplexed scan controller that shares one hex_7seg_decoder instance between NUM_DIGITS digits of a multi-digit display.
- Holds a frame-coherent snapshot of the value to display.
- Steps a digit index at a fixed refresh rate, with a blanking guard before each digit to suppress ghosting.
- Presents the selected nibble to the decoder and drives the per-digit enables.
- Sits between the adder/result logic and the shared decoder plus digit-driver pins.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; range 2..8.
- REFRESH_DIV, 50000: clock cycles per digit slot; must be greater than BLANK_CYCLES.
- BLANK_CYCLES, 64: cycles at the start of each slot with all digits off; must be at least 1.
- DIGIT_EN_ACTIVE_LOW, 1: 1 = o_digit_en bit is 0 when the digit is on; 0 = bit is 1 when on.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_value  in  4*NUM_DIGITS  value to display; nibble k drives digit k, digit 0 is least significant.
- i_dp  in  NUM_DIGITS  decimal-point request per digit.
- i_load  in  1  1-cycle strobe; captures i_value and i_dp.
- o_nibble  out  4  selected nibble, to the decoder's in port.
- o_dp  out  1  decimal point for the selected digit, active-high.
- o_digit_en  out  NUM_DIGITS  digit enables, polarity set by DIGIT_EN_ACTIVE_LOW.
- o_frame_done  out  1  1-cycle pulse on the last cycle of each full frame.

Behaviour:
- All outputs are registered. Sequential logic uses i_clk with asynchronous active-low reset i_rst_n.
- Reset values:
  - slot counter 0, digit index 0, state BLANK.
  - active and pending registers 0, pending_valid 0.
  - o_nibble 0, o_dp 0, o_frame_done 0.
  - o_digit_en all at the inactive level: all 1s if DIGIT_EN_ACTIVE_LOW=1, else all 0s.
- Slot timing:
  - The slot counter counts 0..REFRESH_DIV-1 and wraps.
  - Counts 0..BLANK_CYCLES-1 are BLANK; the remaining counts are SHOW.
  - On the wrap, the digit index increments and wraps from NUM_DIGITS-1 to 0.
  - Frame length is NUM_DIGITS*REFRESH_DIV cycles.
- State machine (two states):
  - BLANK -> SHOW when count = BLANK_CYCLES-1.
  - SHOW -> BLANK when count = REFRESH_DIV-1.
- Outputs in BLANK:
  - o_digit_en all inactive.
  - o_nibble and o_dp already show the current digit's data, so the decoder settles before the digit turns on.
- Outputs in SHOW:
  - Exactly one o_digit_en bit is active: the bit for the current digit index.
- Output latency: o_nibble, o_dp and o_digit_en reflect the index/state one cycle after the counter transition that selects them.
- Value capture:
  - i_load writes i_value and i_dp into the pending register and sets pending_valid.
  - Frame boundary = first BLANK cycle of digit 0. There, if pending_valid, active <= pending and pending_valid clears.
  - Loads mid-frame never change the frame in progress, so there is no tearing.
- Simultaneous events:
  - i_load on the frame-boundary cycle: the new i_value/i_dp bypass pending and go straight into active. pending_valid ends at 0.
  - Multiple i_load strobes within one frame: the last one wins.
- o_frame_done: asserted for 1 cycle when digit index = NUM_DIGITS-1 and count = REFRESH_DIV-1.
- Reset mid-operation: all state returns immediately (asynchronously) to reset values. Any pending load is discarded.
- i_load held high for multiple cycles: captures every cycle; the last captured value wins.

Optional Feature:
- Macro name: LEADING_ZERO_BLANK_EN.
- With the macro defined:
  - In SHOW, digit k (k at least 1) stays off if nibbles k..NUM_DIGITS-1 of active are all 0 and the dp bits k..NUM_DIGITS-1 are all 0.
  - Digit 0 is always shown.
  - Slot timing and o_frame_done are unchanged.
- Without the macro: every digit is shown in its SHOW phase regardless of value.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, DIGIT_EN_ACTIVE_LOW=1):
1. Reset release with no load -> o_digit_en=4'b1111 for 2 cycles. Then 4'b1110 with o_nibble=0 for 6 cycles. Then digit 1 follows the same pattern.
2. i_load with i_value=16'h1234, i_dp=4'b0100 before a frame boundary -> next frame shows o_nibble 4,3,2,1 on digits 0..3. o_dp=1 only during the digit-2 slot.
3. Free run -> o_frame_done pulses exactly every 32 cycles, coincident with the last SHOW cycle of digit 3.
4. i_load 16'hABCD during the digit-1 slot of a frame showing 16'h1234 -> the rest of that frame still shows 3,2,1. The next frame shows D,C,B,A.
5. i_load 16'h0F00 on the exact frame-boundary cycle -> that same frame shows 0,0,F,0.
6. i_rst_n low during SHOW of digit 2 -> o_digit_en goes to 4'b1111 with no clock edge required. After release, the sequence restarts at digit 0 BLANK with active=0.
7. LEADING_ZERO_BLANK_EN defined, i_value=16'h0050, i_dp=0 -> digits 3 and 2 stay off during their SHOW phases. Digit 1 shows 5 and digit 0 shows 0.
